// File: rtl/regfile_wb_arbiter_if.sv
// Handshake and bus bundle around the register-file writeback arbiter.
//   issue_*   : decode issue request and acceptance
//   rs*/busy  : scoreboard lookups for decode
//   alu_*     : ALU/CSR writeback request channel
//   mem_*     : load-return writeback request channel
//   rf_*      : register-file write port drive
//   ecall_req/drained/busy_count : drain control and status
// Modports: master = surrounding pipeline, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_din;
  logic            ecall_req;
  logic            drained;
  logic [5:0]      busy_count;

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output ecall_req,
    input  issue_ready, rs1_busy, rs2_busy, alu_ready, mem_ready,
    input  rf_we, rf_rd, rf_din, drained, busy_count
  );

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  ecall_req,
    output issue_ready, rs1_busy, rs2_busy, alu_ready, mem_ready,
    output rf_we, rf_rd, rf_din, drained, busy_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard and ecall drain.
// Schedules the single register-file write port between ALU/CSR results
// and load returns, tracks per-register busy bits for decode hazard
// stalls, and drains all pending writes before reporting an ecall halt.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : issue, scoreboard lookup, ALU/mem writeback requests,
//                  registered rf write port, ecall drain control, busy_count
// Build option:
//   RR_ARB_EN    : when defined, simultaneous ALU/mem requests alternate
//                  (opposite of last grant wins); otherwise mem always wins.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input logic                clk,
  input logic                reset_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  busy_count;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_rd;
  logic [XLEN-1:0]   rf_din;
  logic              drained;
`ifdef RR_ARB_EN
  logic              last_grant_mem;
`endif

  logic              issue_ready_c;
  logic              issue_fire_c;
  logic              mem_wins_c;
  logic              mem_gnt_c;
  logic              alu_gnt_c;
  logic              gnt_c;
  logic [IDX_W-1:0]  gnt_rd_c;
  logic [XLEN-1:0]   gnt_data_c;
  logic [NREG-1:0]   set_mask_c;
  logic [NREG-1:0]   clr_mask_c;
  logic [NREG-1:0]   busy_nxt_c;
  logic              drain_done_c;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NREG); i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Issue gating, writeback arbitration and scoreboard next state.
  always_comb begin
    issue_ready_c = (state == ST_RUN) &&
                    (!busy[bus.issue_rd] || (bus.issue_rd == '0));
    issue_fire_c  = bus.issue_valid && issue_ready_c;

`ifdef RR_ARB_EN
    mem_wins_c = !last_grant_mem;
`else
    mem_wins_c = 1'b1;
`endif
    mem_gnt_c  = bus.mem_valid && (!bus.alu_valid || mem_wins_c);
    alu_gnt_c  = bus.alu_valid && !mem_gnt_c;
    gnt_c      = mem_gnt_c || alu_gnt_c;
    gnt_rd_c   = mem_gnt_c ? bus.mem_rd : bus.alu_rd;
    gnt_data_c = mem_gnt_c ? XLEN'(bus.mem_data) : XLEN'(bus.alu_data);

    set_mask_c = issue_fire_c ? (NREG'(1) << bus.issue_rd) : '0;
    clr_mask_c = rf_we ? (NREG'(1) << rf_rd) : '0;
    // Set overrides clear on the same edge; x0 never becomes busy.
    busy_nxt_c = ((busy & ~clr_mask_c) | set_mask_c) & ~NREG'(1);

    drain_done_c = (busy == '0) && !rf_we && !bus.alu_valid && !bus.mem_valid;
  end

  // Registered state: scoreboard, write port, drain FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_RUN;
      busy           <= '0;
      busy_count     <= '0;
      rf_we          <= 1'b0;
      rf_rd          <= '0;
      rf_din         <= '0;
      drained        <= 1'b0;
`ifdef RR_ARB_EN
      last_grant_mem <= 1'b0;
`endif
    end else begin
      busy       <= busy_nxt_c;
      busy_count <= popcount(busy_nxt_c);
      rf_we      <= gnt_c && (gnt_rd_c != '0);
      if (gnt_c) begin
        rf_rd  <= gnt_rd_c;
        rf_din <= gnt_data_c;
      end
`ifdef RR_ARB_EN
      if (gnt_c) last_grant_mem <= mem_gnt_c;
`endif
      drained <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.ecall_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_done_c) begin
            state   <= ST_DONE;
            drained <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_c;
  assign bus.rs1_busy    = busy[bus.rs1];
  assign bus.rs2_busy    = busy[bus.rs2];
  assign bus.alu_ready   = alu_gnt_c;
  assign bus.mem_ready   = mem_gnt_c;
  assign bus.rf_we       = rf_we;
  assign bus.rf_rd       = rf_rd;
  assign bus.rf_din      = 32'(rf_din);
  assign bus.drained     = drained;
  assign bus.busy_count  = busy_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if #(.XLEN(32)) bus ();

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.rs1         = 5'd0;
    bus.rs2         = 5'd0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = 32'd0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = 5'd0;
    bus.mem_data    = 32'd0;
    bus.ecall_req   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset_n = 1'b0;

    // Reset state
    bus.issue_rd = 5'd5;
    #2;
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_busy_count", 32'(bus.busy_count), 32'd0);
    check("rst_drained", 32'(bus.drained), 32'd0);
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    tick();
    reset_n = 1'b1;

    // Single-source write of x5
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    bus.rs1         = 5'd5;
    #1;
    check("x5_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.issue_valid = 1'b0;
    check("x5_busy_count", 32'(bus.busy_count), 32'd1);
    check("x5_rs1_busy", 32'(bus.rs1_busy), 32'd1);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    #1;
    check("x5_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("x5_mem_ready", 32'(bus.mem_ready), 32'd0);
    tick();
    bus.alu_valid = 1'b0;
    check("x5_rf_we", 32'(bus.rf_we), 32'd1);
    check("x5_rf_rd", 32'(bus.rf_rd), 32'd5);
    check("x5_rf_din", bus.rf_din, 32'hDEADBEEF);
    check("x5_rs1_busy_during_we", 32'(bus.rs1_busy), 32'd1);
    tick();
    check("x5_rf_we_off", 32'(bus.rf_we), 32'd0);
    check("x5_rs1_clear", 32'(bus.rs1_busy), 32'd0);
    check("x5_busy_count_0", 32'(bus.busy_count), 32'd0);

    // Simultaneous ALU x3 / mem x4 right after an ALU grant: mem first
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0033;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h0000_0044;
    #1;
    check("sim1_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("sim1_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.mem_valid = 1'b0;
    check("sim1_rf_rd", 32'(bus.rf_rd), 32'd4);
    check("sim1_rf_din", bus.rf_din, 32'h0000_0044);
    #1;
    check("sim2_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("sim2_rf_we", 32'(bus.rf_we), 32'd1);
    check("sim2_rf_rd", 32'(bus.rf_rd), 32'd3);
    check("sim2_rf_din", bus.rf_din, 32'h0000_0033);
    tick();

    // WAW on x7
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    tick();
    check("waw_busy_count", 32'(bus.busy_count), 32'd1);
    check("waw_blocked", 32'(bus.issue_ready), 32'd0);
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h1234_5678;
    #1;
    check("waw_mem_ready", 32'(bus.mem_ready), 32'd1);
    tick();
    bus.mem_valid = 1'b0;
    check("waw_rf_rd", 32'(bus.rf_rd), 32'd7);
    check("waw_rf_din", bus.rf_din, 32'h1234_5678);
    check("waw_blocked_during_we", 32'(bus.issue_ready), 32'd0);
    tick();
    check("waw_unblocked", 32'(bus.issue_ready), 32'd1);
    bus.issue_valid = 1'b0;
    tick();
    check("waw_busy_count_0", 32'(bus.busy_count), 32'd0);

    // Simultaneous requests after a mem grant: build-dependent winner
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_00A3;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h0000_00A4;
    #1;
`ifdef RR_ARB_EN
    check("sim3_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("sim3_mem_ready", 32'(bus.mem_ready), 32'd0);
`else
    check("sim3_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("sim3_mem_ready", 32'(bus.mem_ready), 32'd1);
`endif
    idle_inputs();
    tick();

    // x0 handling
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
    #1;
    check("x0_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    idle_inputs();
    check("x0_busy_count", 32'(bus.busy_count), 32'd0);
    check("x0_rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    check("x0_rf_we_2", 32'(bus.rf_we), 32'd0);

    // Ecall drain with x10, x11 pending
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
    tick();
    bus.issue_rd = 5'd11;
    tick();
    bus.issue_valid = 1'b0;
    check("drain_busy_count", 32'(bus.busy_count), 32'd2);
    bus.ecall_req = 1'b1;
    tick();
    bus.ecall_req = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    #1;
    check("drain_issue_blocked", 32'(bus.issue_ready), 32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h0000_0010;
    tick();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd11; bus.mem_data = 32'h0000_0011;
    check("drain_we_x10", 32'(bus.rf_rd), 32'd10);
    tick();
    bus.mem_valid = 1'b0;
    check("drain_we_x11", 32'(bus.rf_rd), 32'd11);
    check("drain_not_yet", 32'(bus.drained), 32'd0);
    tick();
    check("drain_busy_zero", 32'(bus.busy_count), 32'd0);
    check("drain_not_yet_2", 32'(bus.drained), 32'd0);
    check("drain_still_blocked", 32'(bus.issue_ready), 32'd0);
    tick();
    check("drained_pulse", 32'(bus.drained), 32'd1);
    check("done_issue_blocked", 32'(bus.issue_ready), 32'd0);
    tick();
    check("drained_cleared", 32'(bus.drained), 32'd0);
    check("run_issue_ready", 32'(bus.issue_ready), 32'd1);
    bus.issue_valid = 1'b0;
    tick();

    // Reset mid-write
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd20;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hCAFE_0009;
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b0;
    check("midw_rf_we", 32'(bus.rf_we), 32'd1);
    check("midw_busy_count", 32'(bus.busy_count), 32'd1);
    check("midw_issue_blocked", 32'(bus.issue_ready), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("midw_rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("midw_rst_busy_count", 32'(bus.busy_count), 32'd0);
    check("midw_rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("midw_rst_rf_din", bus.rf_din, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_rf_we", 32'(bus.rf_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
